// File: rtl/escape_room_sequencer.sv
// Game-level escape-room sequencer: one room at a time, 2-bit answers over a
// valid/ready handshake, per-attempt countdown, lives, and win/lose reporting.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start after reset
// S_ASK     | presenting a room; ans_ready high, attempt timer counting down
// S_PENALTY | lockout after a wrong answer or timeout; timer counting down
// S_WIN     | all rooms solved; waits for start
// S_LOSE    | out of lives; waits for start
module escape_room_sequencer #(
    parameter int unsigned              NUM_ROOMS      = 5,
    parameter logic [2*NUM_ROOMS-1:0]   ANSWER_KEY     = 10'b00_01_01_00_01,
    parameter int unsigned              LIVES          = 3,
    parameter int unsigned              TIME_LIMIT     = 16,
    parameter int unsigned              PENALTY_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       ans_valid,
    input  logic [1:0] ans,
    output logic       ans_ready,
    output logic [2:0] room,
    output logic [2:0] lives,
    output logic [7:0] timer,
    output logic       correct,
    output logic       wrong,
    output logic       win,
    output logic       lose
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASK,
        S_PENALTY,
        S_WIN,
        S_LOSE
    } state_t;

    // Key padded to the 8-room maximum so the room index selects without width games.
    localparam logic [15:0] KEY_PAD    = 16'(ANSWER_KEY);
    localparam logic [2:0]  LAST_ROOM  = 3'(NUM_ROOMS - 1);
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
    localparam logic [7:0]  TIME_FULL  = 8'(TIME_LIMIT - 1);
    localparam logic [7:0]  PEN_FULL   = 8'(PENALTY_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] room_q, room_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] timer_q, timer_d;
    logic       correct_q, correct_d;
    logic       wrong_q, wrong_d;
    logic       accept;
    logic [1:0] room_key;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            room_q    <= 3'd0;
            lives_q   <= LIVES_INIT;
            timer_q   <= 8'd0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            room_q    <= room_d;
            lives_q   <= lives_d;
            timer_q   <= timer_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
        end
    end

    always_comb begin
        room_key = KEY_PAD[{room_q, 1'b0} +: 2];
    end

    always_comb begin
        state_d   = state_q;
        room_d    = room_q;
        lives_d   = lives_q;
        timer_d   = timer_q;
        correct_d = 1'b0;
        wrong_d   = 1'b0;
        accept    = ans_valid & (state_q == S_ASK);

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_d = S_ASK;
                    room_d  = 3'd0;
                    lives_d = LIVES_INIT;
                    timer_d = TIME_FULL;
                end
            end
            S_ASK: begin
                // An accept on the last timer cycle is an answer, not a timeout.
                if (accept && (ans == room_key)) begin
                    correct_d = 1'b1;
                    if (room_q == LAST_ROOM) begin
                        state_d = S_WIN;
                        timer_d = 8'd0;
                    end else begin
                        room_d  = room_q + 3'd1;
                        timer_d = TIME_FULL;
                    end
                end else if (accept || (timer_q == 8'd0)) begin
                    wrong_d = 1'b1;
                    if (lives_q != 3'd0) begin
                        lives_d = lives_q - 3'd1;
                    end
                    if (lives_q <= 3'd1) begin
                        state_d = S_LOSE;
                        timer_d = 8'd0;
                    end else begin
                        state_d = S_PENALTY;
                        timer_d = PEN_FULL;
                    end
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            S_PENALTY: begin
                if (timer_q == 8'd0) begin
                    state_d = S_ASK;
                    timer_d = TIME_FULL;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ans_ready = (state_q == S_ASK);
    assign room      = room_q;
    assign lives     = lives_q;
    assign timer     = timer_q;
    assign correct   = correct_q;
    assign wrong     = wrong_q;
    assign win       = (state_q == S_WIN);
    assign lose      = (state_q == S_LOSE);

endmodule

// File: tb/tb_escape_room_sequencer.sv
// Directed and randomized bench for escape_room_sequencer, checked every cycle
// against a game-rule reference model.
module tb_escape_room_sequencer;

    localparam int unsigned NUM_ROOMS      = 5;
    localparam logic [9:0]  KEY            = 10'b00_01_01_00_01;
    localparam int unsigned LIVES          = 3;
    localparam int unsigned TIME_LIMIT     = 16;
    localparam int unsigned PENALTY_CYCLES = 4;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       ans_valid;
    logic [1:0] ans;
    logic       ans_ready;
    logic [2:0] room;
    logic [2:0] lives;
    logic [7:0] timer;
    logic       correct;
    logic       wrong;
    logic       win;
    logic       lose;

    int checks;
    int failures;

    string m_mode;
    int    m_room;
    int    m_lives;
    int    m_timer;
    int    m_correct;
    int    m_wrong;

    escape_room_sequencer #(
        .NUM_ROOMS      (NUM_ROOMS),
        .ANSWER_KEY     (KEY),
        .LIVES          (LIVES),
        .TIME_LIMIT     (TIME_LIMIT),
        .PENALTY_CYCLES (PENALTY_CYCLES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .ans_valid (ans_valid),
        .ans       (ans),
        .ans_ready (ans_ready),
        .room      (room),
        .lives     (lives),
        .timer     (timer),
        .correct   (correct),
        .wrong     (wrong),
        .win       (win),
        .lose      (lose)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int key_of(input int r);
        logic [9:0] k;
        k = KEY >> (2 * r);
        return int'(k[1:0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = "idle";
        m_room    = 0;
        m_lives   = LIVES;
        m_timer   = 0;
        m_correct = 0;
        m_wrong   = 0;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [1:0] a);
        m_correct = 0;
        m_wrong   = 0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_mode == "idle" || m_mode == "win" || m_mode == "lose") begin
            if (s) begin
                m_mode  = "ask";
                m_room  = 0;
                m_lives = LIVES;
                m_timer = TIME_LIMIT - 1;
            end
        end else if (m_mode == "ask") begin
            if (v && int'(a) == key_of(m_room)) begin
                m_correct = 1;
                if (m_room == NUM_ROOMS - 1) begin
                    m_mode  = "win";
                    m_timer = 0;
                end else begin
                    m_room  = m_room + 1;
                    m_timer = TIME_LIMIT - 1;
                end
            end else if (v || m_timer == 0) begin
                m_wrong = 1;
                m_lives = m_lives - 1;
                if (m_lives == 0) begin
                    m_mode  = "lose";
                    m_timer = 0;
                end else begin
                    m_mode  = "penalty";
                    m_timer = PENALTY_CYCLES - 1;
                end
            end else begin
                m_timer = m_timer - 1;
            end
        end else begin
            if (m_timer == 0) begin
                m_mode  = "ask";
                m_timer = TIME_LIMIT - 1;
            end else begin
                m_timer = m_timer - 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ans_ready"}, 32'(ans_ready), 32'(m_mode == "ask"));
        chk({tag, ".room"},      32'(room),      m_room);
        chk({tag, ".lives"},     32'(lives),     m_lives);
        chk({tag, ".timer"},     32'(timer),     m_timer);
        chk({tag, ".correct"},   32'(correct),   m_correct);
        chk({tag, ".wrong"},     32'(wrong),     m_wrong);
        chk({tag, ".win"},       32'(win),       32'(m_mode == "win"));
        chk({tag, ".lose"},      32'(lose),      32'(m_mode == "lose"));
    endtask

    task automatic cycle(input logic s, input logic v, input logic [1:0] a);
        start     = s;
        ans_valid = v;
        ans       = a;
        @(posedge clk);
        #1;
        model_step(s, v, a);
        check_all("cyc");
    endtask

    // Idles (optionally holding start) while ans_ready equals 'level'; bounded.
    task automatic wait_while(input logic level, input logic s, output int n);
        n = 0;
        while (ans_ready === level && n < 64) begin
            n++;
            cycle(s, 1'b0, 2'd0);
        end
    endtask

    initial begin
        int n;
        int nc;
        int pa[5];
        logic s, v;
        logic [1:0] a;

        checks    = 0;
        failures  = 0;
        reset_n   = 1'b1;
        start     = 1'b0;
        ans_valid = 1'b0;
        ans       = 2'd0;
        #1 reset_n = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Perfect run
        pa = '{1, 0, 1, 1, 0};
        cycle(1, 0, 0);
        nc = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 2'(pa[i]));
            if (correct === 1'b1) nc++;
        end
        chk("perfect.correct_count", nc, 5);
        chk("perfect.win", 32'(win), 1);
        chk("perfect.lives", 32'(lives), 3);
        chk("perfect.room", 32'(room), 4);

        // Wrong answer in room 2
        cycle(1, 0, 0);
        cycle(0, 1, 1);
        cycle(0, 1, 0);
        cycle(0, 1, 3);
        chk("wrong.pulse", 32'(wrong), 1);
        chk("wrong.lives", 32'(lives), 2);
        wait_while(1'b0, 1'b0, n);
        chk("wrong.penalty_len", n, 4);
        chk("wrong.timer_reload", 32'(timer), 15);
        chk("wrong.room_held", 32'(room), 2);
        cycle(0, 1, 1);
        chk("wrong.next_room", 32'(room), 3);
        cycle(0, 1, 1);
        cycle(0, 1, 0);
        chk("wrong.win", 32'(win), 1);

        // Timeout in room 0
        cycle(1, 0, 0);
        wait_while(1'b1, 1'b0, n);
        chk("timeout.ready_len", n, 16);
        chk("timeout.pulse", 32'(wrong), 1);
        chk("timeout.lives", 32'(lives), 2);
        wait_while(1'b0, 1'b0, n);
        chk("timeout.penalty_len", n, 4);
        chk("timeout.room", 32'(room), 0);

        // Accept on the last timer cycle
        repeat (15) cycle(0, 0, 0);
        chk("boundary.timer0", 32'(timer), 0);
        cycle(0, 1, 1);
        chk("boundary.correct", 32'(correct), 1);
        chk("boundary.not_wrong", 32'(wrong), 0);
        chk("boundary.room", 32'(room), 1);
        chk("boundary.lives", 32'(lives), 2);
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        cycle(0, 1, 0);
        chk("boundary.win", 32'(win), 1);

        // Lose, with start held mid-game, then restart
        cycle(1, 0, 0);
        cycle(0, 1, 3);
        chk("lose.lives2", 32'(lives), 2);
        wait_while(1'b0, 1'b1, n);
        cycle(1, 1, 2);
        chk("lose.lives1", 32'(lives), 1);
        wait_while(1'b0, 1'b1, n);
        cycle(1, 1, 0);
        chk("lose.lives0", 32'(lives), 0);
        chk("lose.level", 32'(lose), 1);
        cycle(1, 0, 0);
        chk("restart.room", 32'(room), 0);
        chk("restart.lives", 32'(lives), 3);
        chk("restart.lose", 32'(lose), 0);
        chk("restart.ready", 32'(ans_ready), 1);

        // Async reset mid-PENALTY, between clock edges
        cycle(0, 1, 3);
        cycle(0, 0, 0);
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("areset");
        cycle(0, 0, 0);
        reset_n = 1'b1;
        cycle(1, 0, 0);
        chk("areset.restart_ready", 32'(ans_ready), 1);
        chk("areset.restart_timer", 32'(timer), 15);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 1) == 1) ? 2'(key_of(m_room)) : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                check_all("rand_areset");
                cycle(0, 0, 0);
                reset_n = 1'b1;
            end
            cycle(s, v, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
